// File: rtl/wave_display_multi.sv
// wave_display_multi: overlays up to CHANNELS sample traces, each in its own
// colour, in the 512x512 window (x 256..767, y 0..511) of a 1024x1024 raster.
// All channel RAMs share one read address {bank, x[8:1]}; the displayed bank
// only switches at the frame-start pixel so a half-drawn frame never tears.
// Pixel path: x/y/valid -> stage 1 (registered coordinate info) -> stage 2
// (sample compare, colour) -> r/g/b/valid_pixel, two edges, one pixel per clock.
// Optional build macro: WAVE_DISPLAY_MULTI_GRID_EN draws a grey 64-pixel grid
// behind the traces.

module wave_display_multi #(
  parameter int                     CHANNELS  = 2,
  parameter int                     SAMPLE_W  = 8,
  parameter logic [24*CHANNELS-1:0] CH_COLORS = {24'hFFFFFF, 24'h00FF00}
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [10:0]                  x,
  input  logic [9:0]                   y,
  input  logic                         valid,
  input  logic                         read_index,
  input  logic [CHANNELS-1:0]          ch_enable,
  input  logic [CHANNELS*SAMPLE_W-1:0] read_value,
  output logic [8:0]                   read_address,
  output logic                         bank,
  output logic                         valid_pixel,
  output logic [7:0]                   r,
  output logic [7:0]                   g,
  output logic [7:0]                   b
);

  logic       in_win;
  logic [8:0] addr;

  logic       bank_q, bank_d;
  logic [8:0] addr_prev_q, addr_prev_d;

  logic       in_win_s1_q, in_win_s1_d;
  logic [7:0] y_s1_q, y_s1_d;
  logic       addr_change_s1_q, addr_change_s1_d;
  logic       line_start_s1_q, line_start_s1_d;
`ifdef WAVE_DISPLAY_MULTI_GRID_EN
  logic       grid_s1_q, grid_s1_d;
`endif

  logic [7:0] plot   [CHANNELS];
  logic [7:0] prev_q [CHANNELS];
  logic [7:0] prev_d [CHANNELS];
  logic [7:0] curr_q [CHANNELS];
  logic [7:0] curr_d [CHANNELS];
  logic [7:0] lo     [CHANNELS];
  logic [7:0] hi     [CHANNELS];
  logic [CHANNELS-1:0] hit;

  logic        valid_pixel_q, valid_pixel_d;
  logic [23:0] rgb_q, rgb_d;

  assign in_win       = valid && (x[9:8] == 2'b01 || x[9:8] == 2'b10) && !y[9];
  assign addr         = {bank_q, x[8:1]};
  assign read_address = addr;
  assign bank         = bank_q;
  assign valid_pixel  = valid_pixel_q;
  assign r            = rgb_q[23:16];
  assign g            = rgb_q[15:8];
  assign b            = rgb_q[7:0];

  // Latch the writer's finished bank only on the frame-start pixel.
  always_comb begin
    bank_d = bank_q;
    if (valid && x == 11'd0 && y == 10'd0) begin
      bank_d = read_index;
    end
  end

  // Stage 1: capture coordinate-derived flags alongside the RAM read.
  always_comb begin
    in_win_s1_d      = in_win;
    y_s1_d           = y[8:1];
    addr_change_s1_d = (addr != addr_prev_q);
    line_start_s1_d  = (x == 11'd256);
    addr_prev_d      = addr;
`ifdef WAVE_DISPLAY_MULTI_GRID_EN
    grid_s1_d        = (x[5:0] == 6'd0) || (y[5:0] == 6'd0);
`endif
  end

  // Flip each channel's top 8 bits so large samples land near the top row.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      plot[c] = 8'd255 - read_value[c*SAMPLE_W + (SAMPLE_W-8) +: 8];
    end
  end

  // Stage 2: advance each channel's sample pair and test the row against the
  // vertical span between the two (post-update) samples.
  always_comb begin
    hit = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      prev_d[c] = prev_q[c];
      curr_d[c] = curr_q[c];
      if (line_start_s1_q) begin
        // first sample of a line stands alone; never join the last line's end
        prev_d[c] = plot[c];
        curr_d[c] = plot[c];
      end else if (addr_change_s1_q) begin
        prev_d[c] = curr_q[c];
        curr_d[c] = plot[c];
      end
      lo[c]  = (prev_d[c] < curr_d[c]) ? prev_d[c] : curr_d[c];
      hi[c]  = (prev_d[c] < curr_d[c]) ? curr_d[c] : prev_d[c];
      hit[c] = ch_enable[c] && in_win_s1_q &&
               (y_s1_q >= lo[c]) && (y_s1_q <= hi[c]);
    end
  end

  // Colour select: lowest-index hit channel wins; grid sits underneath traces.
  always_comb begin
    valid_pixel_d = in_win_s1_q;
    rgb_d         = 24'h000000;
`ifdef WAVE_DISPLAY_MULTI_GRID_EN
    if (in_win_s1_q && grid_s1_q) begin
      rgb_d = 24'h404040;
    end
`endif
    for (int c = CHANNELS-1; c >= 0; c--) begin
      if (hit[c]) begin
        rgb_d = CH_COLORS[c*24 +: 24];
      end
    end
  end

  // All pipeline state; reset flushes to black and returns to bank 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q           <= 1'b0;
      addr_prev_q      <= 9'd0;
      in_win_s1_q      <= 1'b0;
      y_s1_q           <= 8'd0;
      addr_change_s1_q <= 1'b0;
      line_start_s1_q  <= 1'b0;
`ifdef WAVE_DISPLAY_MULTI_GRID_EN
      grid_s1_q        <= 1'b0;
`endif
      for (int c = 0; c < CHANNELS; c++) begin
        prev_q[c] <= 8'd0;
        curr_q[c] <= 8'd0;
      end
      valid_pixel_q    <= 1'b0;
      rgb_q            <= 24'h000000;
    end else begin
      bank_q           <= bank_d;
      addr_prev_q      <= addr_prev_d;
      in_win_s1_q      <= in_win_s1_d;
      y_s1_q           <= y_s1_d;
      addr_change_s1_q <= addr_change_s1_d;
      line_start_s1_q  <= line_start_s1_d;
`ifdef WAVE_DISPLAY_MULTI_GRID_EN
      grid_s1_q        <= grid_s1_d;
`endif
      for (int c = 0; c < CHANNELS; c++) begin
        prev_q[c] <= prev_d[c];
        curr_q[c] <= curr_d[c];
      end
      valid_pixel_q    <= valid_pixel_d;
      rgb_q            <= rgb_d;
    end
  end

endmodule
